// File: rtl/am_pkg.sv
// Shared types and constants for the AM envelope / depth detector.
package am_pkg;

  typedef logic signed [15:0] q15_t;

  localparam logic [14:0] Q15_ONE = 15'd32767;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_DONE
  } div_state_t;

endpackage

// File: rtl/am_env_detect_if.sv
// Start/busy/done handshake between the depth tracker and its divider.
interface am_env_detect_if;

  logic        start;
  logic        abort;
  logic [16:0] num;
  logic [16:0] den;
  logic        busy;
  logic        done;
  logic [15:0] quot;

  modport master (
    output start, abort, num, den,
    input  busy, done, quot
  );

  modport slave (
    input  start, abort, num, den,
    output busy, done, quot
  );

endinterface

// File: rtl/am_div_q15.sv
// Restoring divider: quot = min(floor(num*32768/den), 32767), 0 if den == 0.
module am_div_q15
  import am_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  am_env_detect_if.slave  div
);

  div_state_t  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [16:0] rem, rem_nx;
  logic [16:0] den, den_nx;
  logic [15:0] sh, sh_nx;
  logic [15:0] q, q_nx;
  logic [17:0] trial;
  logic [16:0] diff;
  logic        ge;

  assign trial = {rem, sh[15]};
  assign ge    = trial >= {1'b0, den};
  assign diff  = trial[16:0] - den;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= D_IDLE;
      cnt   <= '0;
      rem   <= '0;
      den   <= '0;
      sh    <= '0;
      q     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rem   <= rem_nx;
      den   <= den_nx;
      sh    <= sh_nx;
      q     <= q_nx;
    end
  end

  // num <= den, so num>>1 < den and 16 quotient bits suffice
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    den_nx   = den;
    sh_nx    = sh;
    q_nx     = q;
    unique case (state)
      D_IDLE: begin
        if (div.start) begin
          state_nx = D_RUN;
          cnt_nx   = '0;
          rem_nx   = {1'b0, div.num[16:1]};
          sh_nx    = {div.num[0], 15'd0};
          den_nx   = div.den;
          q_nx     = '0;
        end
      end
      D_RUN: begin
        rem_nx = ge ? diff : trial[16:0];
        sh_nx  = {sh[14:0], 1'b0};
        q_nx   = {q[14:0], ge};
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'hf) state_nx = D_DONE;
      end
      D_DONE:  state_nx = D_IDLE;
      default: state_nx = D_IDLE;
    endcase
    if (div.abort) state_nx = D_IDLE;
  end

  always_comb begin
    div.quot = q;
    if (den == '0)  div.quot = '0;
    else if (q[15]) div.quot = {1'b0, Q15_ONE};
  end

  assign div.busy = state != D_IDLE;
  assign div.done = state == D_DONE;

endmodule

// File: rtl/am_env_detect.sv
// AM envelope detector with optional modulation-depth measurement.
// Depth path built only with AM_ENV_DETECT_DEPTH_EN defined.
module am_env_detect
  import am_pkg::*;
#(
  parameter int WIN_LOG2  = 6,
  parameter int MEAS_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_valid,
  input  q15_t        i_sample,
  output logic        o_env_valid,
  output logic [15:0] o_env_q15,
  output logic        o_depth_valid,
  output logic [15:0] o_depth_q15,
  output logic        o_overrun
);

  localparam int AW = 15 + WIN_LOG2;

  if (WIN_LOG2 < 1 || WIN_LOG2 > 10 ||
      MEAS_LOG2 < 1 || MEAS_LOG2 > 12) begin : g_bad
    $error("am_env_detect: parameter out of range");
  end

  logic [14:0]         rect;
  logic [AW-1:0]       acc, acc_sum;
  logic [WIN_LOG2-1:0] scnt;

  // -32768 has no positive twin; saturate it
  always_comb begin
    rect = i_sample[14:0];
    if (i_sample[15]) begin
      if (i_sample[14:0] == '0) rect = Q15_ONE;
      else rect = ~i_sample[14:0] + 15'd1;
    end
  end

  assign acc_sum = acc + AW'(rect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      scnt        <= '0;
      o_env_valid <= 1'b0;
      o_env_q15   <= '0;
    end else if (!i_enable) begin
      acc         <= '0;
      scnt        <= '0;
      o_env_valid <= 1'b0;
    end else begin
      o_env_valid <= 1'b0;
      if (i_valid) begin
        scnt <= scnt + WIN_LOG2'(1);
        if (&scnt) begin
          acc         <= '0;
          o_env_q15   <= {1'b0, acc_sum[AW-1:WIN_LOG2]};
          o_env_valid <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

`ifdef AM_ENV_DETECT_DEPTH_EN

  logic [MEAS_LOG2-1:0] wcnt;
  logic [14:0]          mn, mx;
  logic [14:0]          cur_mn, cur_mx;
  logic                 close;

  am_env_detect_if div ();

  assign cur_mn = (o_env_q15[14:0] < mn) ? o_env_q15[14:0] : mn;
  assign cur_mx = (o_env_q15[14:0] > mx) ? o_env_q15[14:0] : mx;
  assign close  = o_env_valid & (&wcnt);

  assign div.start = i_enable & close & ~div.busy;
  assign div.abort = ~i_enable;
  assign div.num   = {2'b0, cur_mx - cur_mn};
  assign div.den   = {2'b0, cur_mx} + {2'b0, cur_mn};

  am_div_q15 u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt          <= '0;
      mn            <= Q15_ONE;
      mx            <= '0;
      o_overrun     <= 1'b0;
      o_depth_valid <= 1'b0;
      o_depth_q15   <= '0;
    end else if (!i_enable) begin
      wcnt          <= '0;
      mn            <= Q15_ONE;
      mx            <= '0;
      o_depth_valid <= 1'b0;
    end else begin
      o_depth_valid <= div.done;
      if (div.done) o_depth_q15 <= div.quot;
      if (o_env_valid) begin
        wcnt <= wcnt + MEAS_LOG2'(1);
        if (close) begin
          mn <= Q15_ONE;
          mx <= '0;
          if (div.busy) o_overrun <= 1'b1;
        end else begin
          mn <= cur_mn;
          mx <= cur_mx;
        end
      end
    end
  end

`else

  assign o_depth_valid = 1'b0;
  assign o_depth_q15   = '0;
  assign o_overrun     = 1'b0;

`endif

endmodule

// File: tb/tb_am_env_detect.sv
// Directed bench for am_env_detect: vector table plus depth/reset/overrun runs.
module tb_am_env_detect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, v0, en1, v1;
  logic [15:0] s0, s1;
  logic        ev0, dv0, ov0, ev1, dv1, ov1;
  logic [15:0] e0, d0, e1, d1;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_env0 = 0;
  int t_dep0 = 0;
  int n_dep0 = 0;
  int n_dep1 = 0;
  int tp1 [2];
  int base;

  typedef struct {
    bit en;
    bit vld;
    int smp;
    int ev;
    int env;
  } vec_t;

  vec_t tbl [20];

  always #5 clk = ~clk;

  am_env_detect #(.WIN_LOG2(2), .MEAS_LOG2(1)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (en0),
    .i_valid       (v0),
    .i_sample      (s0),
    .o_env_valid   (ev0),
    .o_env_q15     (e0),
    .o_depth_valid (dv0),
    .o_depth_q15   (d0),
    .o_overrun     (ov0)
  );

  am_env_detect #(.WIN_LOG2(1), .MEAS_LOG2(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (en1),
    .i_valid       (v1),
    .i_sample      (s1),
    .o_env_valid   (ev1),
    .o_env_q15     (e1),
    .o_depth_valid (dv1),
    .o_depth_q15   (d1),
    .o_overrun     (ov1)
  );

  // values seen here are those of the cycle just ending
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ev0) t_env0 <= cyc;
    if (dv0) begin
      t_dep0 <= cyc;
      n_dep0 <= n_dep0 + 1;
    end
    if (dv1) begin
      if (n_dep1 < 2) tp1[n_dep1] <= cyc;
      n_dep1 <= n_dep1 + 1;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed0(input int n, input int val);
    en0 = 1'b1;
    v0  = 1'b1;
    s0  = 16'(val);
    repeat (n) step();
  endtask

  task automatic wait_dep0(input int b);
    for (int k = 0; k < 40 && n_dep0 == b; k++) step();
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 16384, 0, 0};
    tbl[1]  = '{1, 1, 16384, 0, 0};
    tbl[2]  = '{1, 1, 16384, 0, 0};
    tbl[3]  = '{1, 1, 16384, 1, 16384};
    tbl[4]  = '{1, 1, -32768, 0, 16384};
    tbl[5]  = '{1, 0, 999, 0, 16384};
    tbl[6]  = '{1, 1, -32768, 0, 16384};
    tbl[7]  = '{1, 1, -32768, 0, 16384};
    tbl[8]  = '{1, 1, -32768, 1, 32767};
    tbl[9]  = '{1, 1, 100, 0, 32767};
    tbl[10] = '{1, 1, -200, 0, 32767};
    tbl[11] = '{1, 1, 7, 0, 32767};
    tbl[12] = '{1, 1, -1, 1, 77};
    tbl[13] = '{1, 1, 1000, 0, 77};
    tbl[14] = '{1, 1, 1000, 0, 77};
    tbl[15] = '{0, 1, 1000, 0, 77};
    tbl[16] = '{1, 1, 4, 0, 77};
    tbl[17] = '{1, 1, 4, 0, 77};
    tbl[18] = '{1, 1, 4, 0, 77};
    tbl[19] = '{1, 1, 4, 1, 4};

    rst_n = 1'b0;
    en0 = 1'b0; v0 = 1'b0; s0 = '0;
    en1 = 1'b0; v1 = 1'b0; s1 = '0;
    repeat (2) step();
    check("rst_ev0", int'(ev0), 0);
    check("rst_env0", int'(e0), 0);
    check("rst_dv0", int'(dv0), 0);
    check("rst_dep0", int'(d0), 0);
    check("rst_ov0", int'(ov0), 0);
    check("rst_ev1", int'(ev1), 0);
    check("rst_env1", int'(e1), 0);
    check("rst_dv1", int'(dv1), 0);
    check("rst_dep1", int'(d1), 0);
    check("rst_ov1", int'(ov1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      en0 = tbl[i].en;
      v0  = tbl[i].vld;
      s0  = 16'(tbl[i].smp);
      step();
      check($sformatf("vec%0d_ev", i), int'(ev0), tbl[i].ev);
      check($sformatf("vec%0d_env", i), int'(e0), tbl[i].env);
      check($sformatf("vec%0d_dv", i), int'(dv0), 0);
    end

    // envelopes 24576 then 8192
    pulse_rst();
    base = n_dep0;
    feed0(4, 24576);
    feed0(4, 8192);
    v0 = 1'b0;
    wait_dep0(base);
`ifdef AM_ENV_DETECT_DEPTH_EN
    check("a_seen", n_dep0 - base, 1);
    check("a_latency", t_dep0 - t_env0, 18);
    check("a_depth", int'(d0), 16384);
`else
    check("a_none", n_dep0 - base, 0);
    check("a_depth", int'(d0), 0);
`endif

    // all-zero input, den = 0
    base = n_dep0;
    feed0(8, 0);
    v0 = 1'b0;
    wait_dep0(base);
`ifdef AM_ENV_DETECT_DEPTH_EN
    check("b_seen", n_dep0 - base, 1);
`else
    check("b_none", n_dep0 - base, 0);
`endif
    check("b_depth", int'(d0), 0);

    // envelopes 32767 then 0 clamp
    base = n_dep0;
    feed0(4, 32767);
    check("c_env_hi", int'(e0), 32767);
    feed0(4, 0);
    check("c_env_lo", int'(e0), 0);
    v0 = 1'b0;
    wait_dep0(base);
`ifdef AM_ENV_DETECT_DEPTH_EN
    check("c_seen", n_dep0 - base, 1);
    check("c_depth", int'(d0), 32767);
`else
    check("c_none", n_dep0 - base, 0);
    check("c_depth", int'(d0), 0);
`endif

    // reset five cycles into a division
    feed0(4, 24576);
    feed0(4, 8192);
    v0 = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    check("d_rst_ev", int'(ev0), 0);
    check("d_rst_env", int'(e0), 0);
    check("d_rst_dv", int'(dv0), 0);
    check("d_rst_dep", int'(d0), 0);
    check("d_rst_ov", int'(ov0), 0);
    rst_n = 1'b1;
    base = n_dep0;
    repeat (30) step();
    check("d_no_depth", n_dep0 - base, 0);
    check("d_dep_hold", int'(d0), 0);

    // continuous input on the short-window instance
    en0 = 1'b0;
    en1 = 1'b1;
    v1  = 1'b1;
    s1  = 16'd20000;
    repeat (100) step();
    check("e_env", int'(e1), 20000);
    v1 = 1'b0;
    repeat (30) step();
`ifdef AM_ENV_DETECT_DEPTH_EN
    check("e_ov", int'(ov1), 1);
    check("e_pulses", n_dep1, 5);
    check("e_interval", tp1[1] - tp1[0], 20);
    check("e_depth", int'(d1), 0);
`else
    check("e_ov", int'(ov1), 0);
    check("e_pulses", n_dep1, 0);
`endif
    en1 = 1'b0;
    repeat (3) step();
`ifdef AM_ENV_DETECT_DEPTH_EN
    check("e_ov_sticky", int'(ov1), 1);
`else
    check("e_ov_sticky", int'(ov1), 0);
`endif
    check("e_env_hold", int'(e1), 20000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/am_env_detect.md
AM_ENV_DETECT -- requirements
Module: am_env_detect

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 6, envelope averaging block length of 2^WIN_LOG2 accepted samples, legal range 1..10.
REQ-002 SHALL have parameter MEAS_LOG2, default 4, depth measurement window of 2^MEAS_LOG2 envelope outputs, legal range 1..12.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_enable, input, 1 bit: detector runs only when high.
REQ-006 SHALL have port i_valid, input, 1 bit: i_sample is accepted on cycles where i_valid and i_enable are both high.
REQ-007 SHALL have port i_sample, input, 16 bits: signed Q1.15 AM-modulated carrier sample.
REQ-008 SHALL have port o_env_valid, output, 1 bit: one-cycle pulse marking a new envelope value.
REQ-009 SHALL have port o_env_q15, output, 16 bits: unsigned envelope, range 0..32767.
REQ-010 SHALL have port o_depth_valid, output, 1 bit: one-cycle pulse marking a new depth value.
REQ-011 SHALL have port o_depth_q15, output, 16 bits: measured modulation depth, range 0..32767.
REQ-012 SHALL have port o_overrun, output, 1 bit: sticky flag, set when a depth window is dropped.

Function
REQ-013 SHALL rectify each accepted sample as |x|, with -32768 saturating to 32767 (15-bit result).
REQ-014 SHALL sum rectified samples in a (15+WIN_LOG2)-bit accumulator (integrate-and-dump).
REQ-015 On the 2^WIN_LOG2-th accepted sample, SHALL register o_env_q15 = sum >> WIN_LOG2 (truncating), pulse o_env_valid on the next cycle, and restart the sum from zero with no sample lost.
REQ-016 SHALL track the minimum and maximum of o_env_q15 over each block of 2^MEAS_LOG2 envelope outputs, then reinitialise min to 32767 and max to 0 for the next window.
REQ-017 At window close, SHALL compute num = max-min and den = max+min (17 bits), then depth = floor(num*32768/den), clamped to 32767; depth = 0 when den = 0.
REQ-018 SHALL compute the division in a sequential restoring divider with states D_IDLE -> D_RUN (16 iterations) -> D_DONE -> D_IDLE.
REQ-019 The divider SHALL load operands the cycle after the closing o_env_valid pulse; o_depth_valid SHALL pulse exactly 18 cycles after that o_env_valid pulse.
REQ-020 If a window closes while the divider is not in D_IDLE, SHALL discard that window's result, set o_overrun, and leave the running division unaffected.
REQ-021 While i_enable is low, SHALL synchronously clear the accumulator, sample and window counters, and min/max, abort the divider to D_IDLE, and hold the valids at 0. o_env_q15 and o_depth_q15 SHALL hold their last values.
REQ-022 Samples with i_valid low SHALL leave all state unchanged except the divider, which continues iterating.

Reset
REQ-023 While rst_n is low, SHALL immediately clear all outputs, the accumulator, the counters and o_overrun, set min to 32767 and max to 0, and set the divider to D_IDLE.
REQ-024 Reset asserted mid-division SHALL discard the division; no o_depth_valid pulse SHALL follow deassertion.

Configuration
REQ-025 With macro AM_ENV_DETECT_DEPTH_EN defined, SHALL include min/max tracking, the divider and o_overrun per REQ-016..REQ-020.
REQ-026 Without AM_ENV_DETECT_DEPTH_EN, SHALL tie o_depth_valid, o_depth_q15 and o_overrun to 0, instantiate no divider, keep all ports, and leave envelope behaviour identical.

Structure
REQ-027 Shared package am_pkg SHALL hold the Q1.15 typedef, the constant Q15_ONE = 32767 and the divider state enum.
REQ-028 The divider SHALL be a separate sub-module am_div_q15 (start/busy/done handshake, 17-bit operands, 16-bit clamped quotient).

Verification
REQ-029 WIN_LOG2=2, constant i_sample 16384 on every cycle -> o_env_q15 = 16384, with o_env_valid pulsing every 4 cycles, one cycle after each 4th sample.
REQ-030 WIN_LOG2=2, constant i_sample -32768 -> o_env_q15 = 32767.
REQ-031 WIN_LOG2=2, MEAS_LOG2=1, envelope alternating 24576/8192 -> o_depth_q15 = 16384, exactly 18 cycles after the closing o_env_valid.
REQ-032 All-zero input -> o_depth_q15 = 0 (den = 0 case); envelope 32767/0 -> o_depth_q15 = 32767 (clamp).
REQ-033 rst_n pulsed low 5 cycles into a division -> no o_depth_valid pulse and all outputs 0; i_enable dropped mid-block -> the next block restarts with a full 2^WIN_LOG2 samples.
REQ-034 WIN_LOG2=1, MEAS_LOG2=1, continuous input -> o_overrun sets and stays set; the dropped windows produce no o_depth_valid.
